// File: rtl/parity_frame_checker.sv
// parity_frame_checker
//   Multi-channel serial parity frame checker. Every channel receives frames of
//   DATA_BITS data bits followed by one parity bit. It keeps the running parity
//   of the current frame, reports a one-cycle result per completed frame, and
//   counts parity errors in a saturating per-channel counter.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bit_in     : serial data bit, one per channel
//   bit_valid  : bit_in[i] is accepted at the edge where bit_valid[i] = 1
//   sof        : qualified by bit_valid; the accepted bit is the first data bit of a frame
//   clr_cnt    : synchronous clear of all error counters (wins over an increment)
//   parity_z   : registered running XOR of the bits accepted in the current frame
//   busy       : channel is inside a frame (DATA or PAR state)
//   frame_done : one-cycle pulse, frame completed
//   frame_err  : parity error of the completing frame, only ever high with frame_done
//   sof_err    : one-cycle pulse, frame aborted by an early sof
//   err_count  : per-channel saturating error counts, channel i at [i*ERR_CNT_W +: ERR_CNT_W]
module parity_frame_checker #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned ODD_PARITY = 0,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           bit_in,
  input  logic [NUM_CH-1:0]           bit_valid,
  input  logic [NUM_CH-1:0]           sof,
  input  logic                        clr_cnt,
  output logic [NUM_CH-1:0]           parity_z,
  output logic [NUM_CH-1:0]           busy,
  output logic [NUM_CH-1:0]           frame_done,
  output logic [NUM_CH-1:0]           frame_err,
  output logic [NUM_CH-1:0]           sof_err,
  output logic [NUM_CH*ERR_CNT_W-1:0] err_count
);

  localparam int unsigned          CntW    = $clog2(DATA_BITS + 1);
  localparam logic                 OddBit  = (ODD_PARITY != 0);
  localparam logic [CntW-1:0]      LastCnt = CntW'(DATA_BITS);
  localparam logic [ERR_CNT_W-1:0] ErrMax  = '1;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StPar
  } state_e;

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   par_q, par_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;
    logic                   sof_err_q, sof_err_d;
    logic [ERR_CNT_W-1:0]   errc_q, errc_d;
    logic                   par_next;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      par_d     = par_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;
      sof_err_d = 1'b0;
      par_next  = par_q ^ bit_in[g];

      if (bit_valid[g]) begin
        if (sof[g]) begin
          // An sof always starts a new frame; inside a frame it also aborts the old one.
          sof_err_d = (state_q != StIdle);
          par_d     = bit_in[g];
          cnt_d     = CntW'(1);
          state_d   = (DATA_BITS == 1) ? StPar : StData;
        end else begin
          unique case (state_q)
            StIdle: begin
              // Bits outside a frame are dropped until the next sof.
            end
            StData: begin
              par_d = par_next;
              cnt_d = cnt_q + 1'b1;
              if (cnt_d == LastCnt) begin
                state_d = StPar;
              end
            end
            StPar: begin
              par_d   = par_next;
              cnt_d   = '0;
              state_d = StIdle;
              done_d  = 1'b1;
              ferr_d  = (par_next != OddBit);
            end
            default: begin
              state_d = StIdle;
            end
          endcase
        end
      end

      errc_d = errc_q;
      if (clr_cnt) begin
        errc_d = '0;
      end else if (ferr_d && (errc_q != ErrMax)) begin
        errc_d = errc_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        par_q     <= 1'b0;
        done_q    <= 1'b0;
        ferr_q    <= 1'b0;
        sof_err_q <= 1'b0;
        errc_q    <= '0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        par_q     <= par_d;
        done_q    <= done_d;
        ferr_q    <= ferr_d;
        sof_err_q <= sof_err_d;
        errc_q    <= errc_d;
      end
    end

    assign parity_z[g]                          = par_q;
    assign busy[g]                              = (state_q != StIdle);
    assign frame_done[g]                        = done_q;
    assign frame_err[g]                         = ferr_q;
    assign sof_err[g]                           = sof_err_q;
    assign err_count[g*ERR_CNT_W +: ERR_CNT_W]  = errc_q;
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker. Two instances share all inputs: an even-parity
// one with 2-bit error counters and an odd-parity one with 8-bit counters.
// Expected frame results are queued as frames are driven and compared by a
// monitor when the DUT pulses frame_done or sof_err.
module tb_parity_frame_checker;

  localparam int NumCh = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NumCh-1:0]     bit_in;
  logic [NumCh-1:0]     bit_valid;
  logic [NumCh-1:0]     sof;
  logic                 clr_cnt;

  logic [NumCh-1:0]     par_e, busy_e, done_e, ferr_e, serr_e;
  logic [NumCh*2-1:0]   cnt_e;
  logic [NumCh-1:0]     par_o, busy_o, done_o, ferr_o, serr_o;
  logic [NumCh*8-1:0]   cnt_o;

  parity_frame_checker #(
    .NUM_CH(NumCh), .DATA_BITS(8), .ODD_PARITY(0), .ERR_CNT_W(2)
  ) dut_even (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .clr_cnt(clr_cnt), .parity_z(par_e), .busy(busy_e), .frame_done(done_e),
    .frame_err(ferr_e), .sof_err(serr_e), .err_count(cnt_e)
  );

  parity_frame_checker #(
    .NUM_CH(NumCh), .DATA_BITS(8), .ODD_PARITY(1), .ERR_CNT_W(8)
  ) dut_odd (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .clr_cnt(clr_cnt), .parity_z(par_o), .busy(busy_o), .frame_done(done_o),
    .frame_err(ferr_o), .sof_err(serr_o), .err_count(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // kind: 2'b01 = frame_done, 2'b10 = sof_err ({sof_err, frame_done})
  typedef struct {
    int         ch;
    logic [1:0] kind;
    logic       ferr_e;
    logic       ferr_o;
    logic       par;
    logic [1:0] cnt_e;
    logic [7:0] cnt_o;
  } exp_t;

  exp_t sb_q[$];
  int   mod_cnt_e[NumCh];
  int   mod_cnt_o[NumCh];

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NumCh; c++) begin
        check("ferr_without_done", {30'd0, ferr_e[c] & ~done_e[c], ferr_o[c] & ~done_o[c]}, 0);
        if (done_e[c] || serr_e[c] || done_o[c] || serr_o[c]) begin
          if (sb_q.size() == 0) begin
            check($sformatf("unexpected_pulse_ch%0d", c), {30'd0, serr_e[c], done_e[c]}, 0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("event_ch", c, e.ch);
            check("kind_even", {30'd0, serr_e[c], done_e[c]}, {30'd0, e.kind});
            check("kind_odd", {30'd0, serr_o[c], done_o[c]}, {30'd0, e.kind});
            check("ferr_even", {31'd0, ferr_e[c]}, {31'd0, e.ferr_e});
            check("ferr_odd", {31'd0, ferr_o[c]}, {31'd0, e.ferr_o});
            check("parity_z_even", {31'd0, par_e[c]}, {31'd0, e.par});
            check("parity_z_odd", {31'd0, par_o[c]}, {31'd0, e.par});
            check("err_count_even", {30'd0, cnt_e[c*2 +: 2]}, {30'd0, e.cnt_e});
            check("err_count_odd", {24'd0, cnt_o[c*8 +: 8]}, {24'd0, e.cnt_o});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit_valid = '0;
    sof       = '0;
    bit_in    = '0;
    clr_cnt   = 1'b0;
    repeat (n) step();
  endtask

  // Present one bit on one channel for exactly one accepting edge.
  task automatic put(input int ch, input logic b, input logic s, input logic clr);
    bit_valid     = '0;
    sof           = '0;
    bit_in        = '0;
    bit_valid[ch] = 1'b1;
    sof[ch]       = s;
    bit_in[ch]    = b;
    clr_cnt       = clr;
    step();
    bit_valid = '0;
    sof       = '0;
    bit_in    = '0;
    clr_cnt   = 1'b0;
  endtask

  // Data goes out MSB first; gaps of 1..maxgap idle cycles follow each data bit.
  task automatic send_frame(input int ch, input logic [7:0] data, input logic pbit,
                            input int maxgap, input logic abort, input logic clr);
    logic total;
    exp_t e;
    total = (^data) ^ pbit;
    if (abort) begin
      e = '{ch: ch, kind: 2'b10, ferr_e: 1'b0, ferr_o: 1'b0, par: data[7],
            cnt_e: 2'(mod_cnt_e[ch]), cnt_o: 8'(mod_cnt_o[ch])};
      sb_q.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      put(ch, data[7-i], (i == 0), 1'b0);
      if (i == 0) begin
        check("busy_after_sof", {30'd0, busy_e[ch], busy_o[ch]}, 32'd3);
      end
      if (maxgap > 0) idle($urandom_range(maxgap, 1));
    end
    if (clr) begin
      for (int c = 0; c < NumCh; c++) begin
        mod_cnt_e[c] = 0;
        mod_cnt_o[c] = 0;
      end
    end else begin
      if (total != 1'b0 && mod_cnt_e[ch] < 3)   mod_cnt_e[ch]++;
      if (total != 1'b1 && mod_cnt_o[ch] < 255) mod_cnt_o[ch]++;
    end
    e = '{ch: ch, kind: 2'b01, ferr_e: (total != 1'b0), ferr_o: (total != 1'b1), par: total,
          cnt_e: 2'(mod_cnt_e[ch]), cnt_o: 8'(mod_cnt_o[ch])};
    sb_q.push_back(e);
    put(ch, pbit, 1'b0, clr);
    check("busy_after_parity", {30'd0, busy_e[ch], busy_o[ch]}, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_parity_z"}, {24'd0, par_e, par_o}, 0);
    check({tag, "_busy"}, {24'd0, busy_e, busy_o}, 0);
    check({tag, "_pulses"}, {20'd0, done_e, ferr_e, serr_e}, 0);
    check({tag, "_pulses_odd"}, {20'd0, done_o, ferr_o, serr_o}, 0);
    check({tag, "_cnt_even"}, {24'd0, cnt_e}, 0);
    check({tag, "_cnt_odd"}, cnt_o, 0);
  endtask

  logic [7:0] d;
  logic [1:0] sat_seq [5];

  initial begin
    sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3; sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;
    for (int c = 0; c < NumCh; c++) begin
      mod_cnt_e[c] = 0;
      mod_cnt_o[c] = 0;
    end
    rst_n     = 1'b0;
    bit_in    = '0;
    bit_valid = '0;
    sof       = '0;
    clr_cnt   = 1'b0;
    #1;
    check_all_zero("reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Good frame then bad frame on ch0 (four ones in the data).
    send_frame(0, 8'b1011_0010, 1'b0, 0, 1'b0, 1'b0);
    send_frame(0, 8'b1011_0010, 1'b1, 0, 1'b0, 1'b0);
    idle(2);

    // ch1: three bits of a frame, then an early sof restarts it.
    put(1, 1'b1, 1'b1, 1'b0);
    put(1, 1'b0, 1'b0, 1'b0);
    put(1, 1'b1, 1'b0, 1'b0);
    send_frame(1, 8'b0110_1110, ^8'b0110_1110, 0, 1'b1, 1'b0);
    idle(2);

    // ch2: stray bits in IDLE are ignored, then a frame with random gaps.
    put(2, 1'b1, 1'b0, 1'b0);
    put(2, 1'b1, 1'b0, 1'b0);
    put(2, 1'b0, 1'b0, 1'b0);
    check("idle_bits_busy", {30'd0, busy_e[2], busy_o[2]}, 0);
    check("idle_bits_parity", {30'd0, par_e[2], par_o[2]}, 0);
    send_frame(2, 8'hA7, ^8'hA7, 5, 1'b0, 1'b0);
    idle(1);

    // ch2: back-to-back bad frames saturate the 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      send_frame(2, d, ~(^d), 0, 1'b0, 1'b0);
      check("sat_count", {30'd0, cnt_e[4 +: 2]}, {30'd0, sat_seq[k]});
    end
    d = 8'($urandom);
    send_frame(2, d, ~(^d), 0, 1'b0, 1'b1);
    check("clr_wins", {30'd0, cnt_e[4 +: 2]}, 0);
    idle(2);

    // ch3: reset in the middle of a frame.
    put(3, 1'b1, 1'b1, 1'b0);
    put(3, 1'b1, 1'b0, 1'b0);
    put(3, 1'b0, 1'b0, 1'b0);
    put(3, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    for (int c = 0; c < NumCh; c++) begin
      mod_cnt_e[c] = 0;
      mod_cnt_o[c] = 0;
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    put(3, 1'b1, 1'b0, 1'b0);
    check("post_reset_bit_busy", {30'd0, busy_e[3], busy_o[3]}, 0);
    check("post_reset_bit_parity", {30'd0, par_e[3], par_o[3]}, 0);
    send_frame(3, 8'b1100_0001, 1'b0, 2, 1'b0, 1'b0);
    send_frame(3, 8'b0000_0000, 1'b0, 0, 1'b0, 1'b0);
    idle(3);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Multi-channel serial parity frame checker.
- Each channel receives a serial bit stream framed as DATA_BITS data bits followed by one parity bit.
- Each channel tracks running parity as a Moore output, flags parity errors per frame, and keeps a saturating error counter per channel.
- Sits after the serial receive front-end; status feeds the link-monitor registers.

Parameters:
NUM_CH, 4, number of independent serial channels (>=1)
DATA_BITS, 8, data bits per frame excluding the parity bit (>=1)
ODD_PARITY, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (XOR must be 1)
ERR_CNT_W, 8, width of each per-channel error counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
bit_in  input  NUM_CH  serial bit per channel
bit_valid  input  NUM_CH  bit_in[i] is accepted at the clock edge where bit_valid[i]=1
sof  input  NUM_CH  qualified by bit_valid; marks the accepted bit as the first data bit of a frame
clr_cnt  input  1  synchronous clear of all error counters
parity_z  output  NUM_CH  registered running XOR of bits accepted in the current frame
busy  output  NUM_CH  channel is in the DATA or PAR state
frame_done  output  NUM_CH  1-cycle pulse: frame complete
frame_err  output  NUM_CH  parity error for the completing frame; meaningful only when frame_done=1, otherwise 0
sof_err  output  NUM_CH  1-cycle pulse: frame aborted by an early sof
err_count  output  NUM_CH*ERR_CNT_W  per-channel saturating error counts; channel i occupies bits [i*ERR_CNT_W +: ERR_CNT_W]

Behaviour:
- Reset (rst_n=0, asynchronous): all channels enter IDLE. All outputs are 0, including parity_z, busy, frame_done, frame_err, sof_err and err_count. The bit counter is 0.
- Channels are fully independent; only clk, rst_n and clr_cnt are shared.
- Per-channel FSM states are IDLE, DATA and PAR. The bit counter is ceil(log2(DATA_BITS+1)) bits wide.
- IDLE:
  - bit_valid & sof: parity_z <= bit_in, cnt <= 1. Go to PAR if DATA_BITS==1, else go to DATA.
  - bit_valid & !sof: bit ignored, no state change, no pulse.
- DATA:
  - bit_valid & !sof: parity_z <= parity_z ^ bit_in, cnt <= cnt+1. Go to PAR when the new cnt == DATA_BITS.
- PAR:
  - bit_valid & !sof: this is the parity bit. parity_z <= parity_z ^ bit_in, go to IDLE.
  - At the same edge: frame_done <= 1 and frame_err <= ((parity_z ^ bit_in) != ODD_PARITY).
- Early sof: bit_valid & sof while in DATA or PAR aborts the current frame.
  - sof_err <= 1 for one cycle. No frame_done is issued and no error count is added.
  - The bit is taken as the first data bit of a new frame, with the same updates as sof in IDLE.
- Latency:
  - parity_z, busy and state update at the accepting edge.
  - frame_done/frame_err/sof_err are high for exactly the one cycle following the accepting edge. They are 0 in every other cycle.
  - A new sof on the cycle immediately after the parity bit is accepted normally; back-to-back frames have zero gap.
- busy = 1 in DATA and PAR, 0 in IDLE.
- parity_z holds its value in IDLE until the next sof. bit_valid=0 cycles leave all state unchanged; gaps are allowed anywhere within a frame.
- err_count[i]:
  - Increments at the same edge that sets frame_err[i]=1.
  - Saturates at 2^ERR_CNT_W-1 and never wraps.
  - clr_cnt=1 sets all counters to 0. If clr_cnt coincides with an increment, clear wins and the result is 0.
- rst_n asserted mid-frame: the partial frame is discarded and no pulses are generated; after release the channel waits in IDLE for sof.

Test Plan:
1. Even mode, DATA_BITS=8, ch0: sof with data 1,0,1,1,0,0,1,0 (four 1s), then parity bit 0 -> frame_done[0]=1 for one cycle, frame_err[0]=0, err_count ch0=0, parity_z[0]=0.
2. Same data with parity bit 1 -> frame_done[0]=1, frame_err[0]=1, err_count ch0=1. ODD_PARITY=1 with the same stimulus -> frame_err=0.
3. ch1: sof, 3 data bits, then sof again, then 8 data bits + correct parity -> sof_err[1] one-cycle pulse; exactly one frame_done[1] with frame_err=0; no other channel changes.
4. Bits with bit_valid=1 and no sof in IDLE, plus bit_valid=0 gaps of 1-5 cycles inside a frame -> IDLE bits ignored; the frame result is identical to the gapless case.
5. ERR_CNT_W=2: five bad frames on ch2 -> count goes 1,2,3,3,3. clr_cnt pulsed on the same cycle as a sixth error -> count=0.
6. Assert rst_n=0 after 4 data bits on ch3 -> all outputs 0 asynchronously. After release, parity bit with no sof -> ignored; a full new frame -> correct result.
